// File: rtl/br_wb_arbiter.sv
// br_wb_arbiter: round-robin write-port arbiter for the BR register bank, with a zeroing sweep after reset.
// Define WB_FWD_EN to add same-cycle read-bypass ports (fwd_a1/fwd_a2/fwd_hit1/fwd_hit2/fwd_data).
module br_wb_arbiter #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  output logic          br_we,
  output logic [AW-1:0] br_a3,
  output logic [DW-1:0] br_wd3,
  output logic          busy
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0] fwd_a1,
  input  logic [AW-1:0] fwd_a2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data
`endif
);

  typedef enum logic {CLEAR, RUN} state_e;

  localparam logic [AW-1:0] CntLast = AW'(NREG - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic          gnt0, gnt1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && cnt_q == CntLast) state_d = RUN;
  end

  // last_q = 1 means s1 won most recently, so s0 wins the next contention
  always_comb begin
    busy = (state_q == CLEAR);
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == RUN) begin
      if (s0_valid && (!s1_valid || last_q)) gnt0 = 1'b1;
      else if (s1_valid)                     gnt1 = 1'b1;
    end
    s0_ready = gnt0;
    s1_ready = gnt1;
  end

  // Writes to x0 are accepted but suppressed; the port registers keep their last value then
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    we_d   = 1'b0;
    a3_d   = a3_q;
    wd3_d  = wd3_q;
    if (state_q == CLEAR) begin
      we_d  = 1'b1;
      a3_d  = cnt_q;
      wd3_d = '0;
      cnt_d = cnt_q + AW'(1);
    end else if (gnt0 && s0_valid) begin
      last_d = 1'b0;
      if (s0_addr != '0) begin
        we_d  = 1'b1;
        a3_d  = s0_addr;
        wd3_d = s0_data;
      end
    end else if (gnt1 && s1_valid) begin
      last_d = 1'b1;
      if (s1_addr != '0) begin
        we_d  = 1'b1;
        a3_d  = s1_addr;
        wd3_d = s1_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= 1'b1;
      we_q   <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      we_q   <= we_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
    end
  end

  assign br_we  = we_q;
  assign br_a3  = a3_q;
  assign br_wd3 = wd3_q;

`ifdef WB_FWD_EN
  // Gated by busy because the clear sweep writes with br_we high
  assign fwd_hit1 = !busy && we_q && (a3_q == fwd_a1) && (fwd_a1 != '0);
  assign fwd_hit2 = !busy && we_q && (a3_q == fwd_a2) && (fwd_a2 != '0);
  assign fwd_data = busy ? '0 : wd3_q;
`endif

endmodule

// File: tb/tb_br_wb_arbiter.sv
// tb_br_wb_arbiter: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
// Forwarding checks are compiled in only when WB_FWD_EN is defined.
module tb_br_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic          clk;
  logic          rst;
  logic          s0_valid, s1_valid;
  logic          s0_ready, s1_ready;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [DW-1:0] s0_data, s1_data;
  logic          br_we;
  logic [AW-1:0] br_a3;
  logic [DW-1:0] br_wd3;
  logic          busy;
  logic [AW-1:0] fwd_a1, fwd_a2;
`ifdef WB_FWD_EN
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  br_wb_arbiter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .br_we(br_we), .br_a3(br_a3), .br_wd3(br_wd3), .busy(busy)
`ifdef WB_FWD_EN
    , .fwd_a1(fwd_a1), .fwd_a2(fwd_a2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a clearing flag with a sweep index, the last winner, and the expected BR port
  bit            mOn = 0;
  bit            mClear = 1;
  int            mIdx = 0;
  bit            mLastS1 = 1;
  bit            mWe = 0;
  logic [AW-1:0] mA3 = '0;
  logic [DW-1:0] mWd3 = '0;
  bit            acc0 = 0, acc1 = 0;

  function automatic int pickOf();
    if (!mOn || mClear)         return -1;
    if (s0_valid && s1_valid)   return mLastS1 ? 0 : 1;
    if (s0_valid)               return 0;
    if (s1_valid)               return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int p;
    p = pickOf();
    acc0 = (p == 0);
    acc1 = (p == 1);
    if (rst) begin
      mOn = 1; mClear = 1; mIdx = 0; mLastS1 = 1;
      mWe = 0; mA3 = '0; mWd3 = '0;
    end else if (mOn) begin
      if (mClear) begin
        mWe = 1; mA3 = AW'(mIdx); mWd3 = '0;
        mIdx++;
        if (mIdx == NREG) mClear = 0;
      end else begin
        mWe = 0;
        if (p >= 0) begin
          mLastS1 = (p == 1);
          if (((p == 1) ? s1_addr : s0_addr) != '0) begin
            mWe  = 1;
            mA3  = (p == 1) ? s1_addr : s0_addr;
            mWd3 = (p == 1) ? s1_data : s0_data;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
  endtask

  // Per-cycle comparison against the model, after the driver has settled the inputs
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (mOn) begin
        int p;
        p = pickOf();
        checkOutput("cyc_br_we", DW'(br_we), DW'(mWe));
        checkOutput("cyc_br_a3", DW'(br_a3), DW'(mA3));
        checkOutput("cyc_br_wd3", br_wd3, mWd3);
        checkOutput("cyc_busy", DW'(busy), DW'(mClear));
        checkOutput("cyc_s0_ready", DW'(s0_ready), DW'(p == 0));
        checkOutput("cyc_s1_ready", DW'(s1_ready), DW'(p == 1));
`ifdef WB_FWD_EN
        checkOutput("cyc_fwd_hit1", DW'(fwd_hit1), DW'(!mClear && mWe && mA3 == fwd_a1 && fwd_a1 != 0));
        checkOutput("cyc_fwd_hit2", DW'(fwd_hit2), DW'(!mClear && mWe && mA3 == fwd_a2 && fwd_a2 != 0));
        checkOutput("cyc_fwd_data", fwd_data, mClear ? '0 : mWd3);
`endif
      end
    end
  end

  initial begin
    rst = 1'b1;
    fwd_a1 = '0;
    fwd_a2 = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset state, with both requesters already asking during the sweep
    @(negedge clk); #2;
    rst = 1'b0;
    applyStimulus(1, 5'd7, 32'h77, 1, 5'd9, 32'h99);
    #1;
    checkOutput("rst_busy", DW'(busy), 1);
    checkOutput("rst_br_we", DW'(br_we), 0);
    checkOutput("rst_br_a3", DW'(br_a3), 0);
    checkOutput("rst_s0_ready", DW'(s0_ready), 0);
    checkOutput("rst_s1_ready", DW'(s1_ready), 0);

    // Clear sweep: a3 walks 0..31 with zero data; busy drops together with the last write
    for (int k = 0; k < NREG; k++) begin
      @(negedge clk); #2;
      if (k == NREG - 2) applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("clr_br_we", DW'(br_we), 1);
      checkOutput("clr_br_a3", DW'(br_a3), DW'(k));
      checkOutput("clr_br_wd3", br_wd3, 0);
      checkOutput("clr_busy", DW'(busy), DW'(k != NREG - 1));
      checkOutput("clr_ready", DW'({s0_ready, s1_ready}), 0);
    end

    // Single write from s0
    @(negedge clk); #2;
    applyStimulus(1, 5'd3, 32'h01233333, 0, 0, 0);
    #1;
    checkOutput("t2_s0_ready", DW'(s0_ready), 1);
    checkOutput("t2_s1_ready", DW'(s1_ready), 0);
    @(negedge clk); #2;
    applyStimulus(0, 0, 0, 0, 0, 0);
    fwd_a1 = 5'd3;
    fwd_a2 = 5'd0;
    #1;
    checkOutput("t2_br_we", DW'(br_we), 1);
    checkOutput("t2_br_a3", DW'(br_a3), 3);
    checkOutput("t2_br_wd3", br_wd3, 32'h01233333);
`ifdef WB_FWD_EN
    checkOutput("t6_fwd_hit1", DW'(fwd_hit1), 1);
    checkOutput("t6_fwd_hit2", DW'(fwd_hit2), 0);
    checkOutput("t6_fwd_data", fwd_data, 32'h01233333);
`endif

    // Write to x0 from s1: accepted but no BR write
    @(negedge clk); #2;
    applyStimulus(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    #1;
    checkOutput("t4_s1_ready", DW'(s1_ready), 1);
    @(negedge clk); #2;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t4_br_we", DW'(br_we), 0);

    // Contention: s1 won last, so grants alternate s0, s1, s0, s1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      if (i == 0) applyStimulus(1, 5'd1, 32'h01231111, 1, 5'd2, 32'h01232222);
      if (i == 4) applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      if (i < 4) begin
        checkOutput("t3_s0_ready", DW'(s0_ready), DW'(i % 2 == 0));
        checkOutput("t3_s1_ready", DW'(s1_ready), DW'(i % 2 == 1));
      end
      if (i > 0) begin
        checkOutput("t3_br_we", DW'(br_we), 1);
        checkOutput("t3_br_a3", DW'(br_a3), ((i - 1) % 2 == 0) ? 1 : 2);
        checkOutput("t3_br_wd3", br_wd3, ((i - 1) % 2 == 0) ? 32'h01231111 : 32'h01232222);
      end
    end

    // Reset in the same cycle as an accepted s0 request
    @(negedge clk); #2;
    applyStimulus(1, 5'd5, 32'hAAAA5555, 0, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("t5_s0_ready", DW'(s0_ready), 1);
    @(negedge clk); #2;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t5_br_we", DW'(br_we), 0);
    checkOutput("t5_busy", DW'(busy), 1);
    @(negedge clk); #3;
    checkOutput("t5_restart_we", DW'(br_we), 1);
    checkOutput("t5_restart_a3", DW'(br_a3), 0);

    // Randomized traffic; requesters hold their request until it is accepted
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      rst = ($urandom % 400 == 0);
      if (!s0_valid || acc0) begin
        s0_valid = ($urandom % 3 != 0);
        s0_addr  = ($urandom % 8 == 0) ? '0 : AW'($urandom);
        s0_data  = $urandom;
      end
      if (!s1_valid || acc1) begin
        s1_valid = ($urandom % 3 != 0);
        s1_addr  = ($urandom % 8 == 0) ? '0 : AW'($urandom);
        s1_data  = $urandom;
      end
      fwd_a1 = ($urandom % 2 == 0) ? mA3 : AW'($urandom);
      fwd_a2 = ($urandom % 3 == 0) ? mA3 : AW'($urandom);
    end

    @(negedge clk); #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
